note_seq_ctrl: RTL and testbench
================================

// Module: note_seq_ctrl
// PURPOSE
//  Control FSM for the note-memory datapath of the music device. Turns debounced user
//  buttons into the datapath strobes: ld_note (record one note), ld_play and note_counter
//  (timed playback of the 16 memory slots), and clear (VGA staff wipe).
//  Sits between the board button/switch logic and the datapath. Owns all tempo timing.
// PARAMETERS
//  NOTE_COUNT    16          number of memory slots stepped during playback (<=16)
//  NOTE_TICKS    12_500_000  clk cycles each note sounds (0.25 s at 50 MHz)
//  GAP_TICKS     1_250_000   muted clk cycles between notes (0 = no gap)
//  CLEAR_CYCLES  19_200      cycles clear is held (one full 160x120 wipe)
// PORTS
//  clk          in   1  system clock, 50 MHz
//  reset        in   1  synchronous, active-low
//  load_btn     in   1  active-high level, already debounced/synchronised
//  play_btn     in   1  active-high level; press starts or stops playback
//  clear_btn    in   1  active-high level; press wipes the display
//  ld_note      out  1  one-cycle write strobe to the datapath
//  ld_play      out  1  high while playback addresses memory
//  note_counter out  4  playback memory address
//  clear        out  1  display clear request
//  mute         out  1  1 = audio output silenced
//  busy         out  1  1 in any state other than IDLE
// BEHAVIOUR
//  Reset: clock is clk; reset is synchronous, active-low. It forces IDLE, all edge registers
//   to 0, ld_note=0, ld_play=0, note_counter=0, clear=0, mute=1, busy=0, timers=0.
//   Reset overrides everything in the same cycle, mid-play and mid-clear included.
//  Edge detect: each button is registered. A press is btn & ~btn_q, one cycle long.
//   Only presses act. A held level never repeats.
//  Priority of presses in the same cycle: clear > play > load.
//  States: IDLE, REC, PLAY_NOTE, PLAY_GAP, CLR.
//  IDLE:
//   - load press goes to REC.
//   - play press loads note_counter=0 and timer=NOTE_TICKS-1, then goes to PLAY_NOTE.
//   - clear press loads timer=CLEAR_CYCLES-1, then goes to CLR.
//  REC: ld_note=1 for exactly this one cycle, then IDLE. This guarantees ld_note is low for
//   at least one cycle between strobes, even on back-to-back presses.
//  PLAY_NOTE: ld_play=1, mute=0. Timer counts down. At 0:
//   - GAP_TICKS>0: timer=GAP_TICKS-1, go to PLAY_GAP.
//   - GAP_TICKS=0: advance directly (see Advance).
//  PLAY_GAP: ld_play=1, mute=1. Timer counts down. At 0, Advance.
//  Advance:
//   - note_counter<NOTE_COUNT-1: note_counter+1, timer=NOTE_TICKS-1, go to PLAY_NOTE.
//   - Last slot: end-of-sequence rule (see CONFIGURATION).
//  In PLAY_*:
//   - play press returns to IDLE next cycle with note_counter=0, mute=1.
//   - clear press aborts to CLR.
//   - load presses are ignored (dropped, never queued).
//  CLR: clear=1, mute=1. Timer counts down. At 0, go to IDLE. Presses are ignored.
//  Outside PLAY_*: ld_play=0. note_counter holds its last value until the next play start.
//  Timers: 24-bit down counters. Widths must cover every parameter.
// CONFIGURATION
//  LOOP_PLAYBACK_EN defined:
//   - After the last slot, note_counter wraps to 0 and playback continues.
//   - Only a play or clear press ends it.
//  LOOP_PLAYBACK_EN undefined:
//   - After the last slot's timing completes, go to IDLE with note_counter=0 and mute=1.
// TESTING (sim with NOTE_TICKS=4, GAP_TICKS=2, CLEAR_CYCLES=8)
//  1. Reset low 2 cycles, then high -> ld_note=ld_play=clear=0, mute=1, busy=0,
//     note_counter=0.
//  2. Hold load_btn 10 cycles -> exactly one ld_note pulse, 1 cycle wide, one cycle after the
//     rising edge.
//  3. Press play -> note_counter steps 0..15. Each note has 4 cycles mute=0 then 2 cycles
//     mute=1. LOOP_PLAYBACK_EN undefined: IDLE after 96 cycles. Defined: wraps to 0.
//  4. Press play at note 5 -> IDLE next cycle, ld_play=0, note_counter=0, mute=1.
//  5. Press clear and play in the same cycle from IDLE -> CLR; clear=1 for exactly 8 cycles.
//     Presses during CLR are ignored.
//  6. Assert reset mid-PLAY_NOTE -> all outputs at reset values the next cycle. No ld_note
//     glitch.

Source files
------------

// File: rtl/note_seq_ctrl.sv
// Control FSM for the note-memory datapath: record strobe, timed playback, display clear.
// Optional LOOP_PLAYBACK_EN: playback wraps to slot 0 instead of stopping after the last slot.
`timescale 1ns/1ps
module note_seq_ctrl #(
    parameter int NOTE_COUNT   = 16,
    parameter int NOTE_TICKS   = 12_500_000,
    parameter int GAP_TICKS    = 1_250_000,
    parameter int CLEAR_CYCLES = 19_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_btn,
    input  logic       play_btn,
    input  logic       clear_btn,
    output logic       ld_note,
    output logic       ld_play,
    output logic [3:0] note_counter,
    output logic       clear,
    output logic       mute,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, REC, PLAY_NOTE, PLAY_GAP, CLR} state_t;

    localparam logic [23:0] NOTE_LOAD  = 24'(NOTE_TICKS - 1);
    localparam logic [23:0] GAP_LOAD   = 24'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [23:0] CLEAR_LOAD = 24'(CLEAR_CYCLES - 1);
    localparam logic [3:0]  LAST_SLOT  = 4'(NOTE_COUNT - 1);

    state_t      state_reg;
    logic [23:0] timer_reg;
    logic        load_q_reg;
    logic        play_q_reg;
    logic        clear_q_reg;

    logic load_press;
    logic play_press;
    logic clear_press;

    assign load_press  = load_btn  & ~load_q_reg;
    assign play_press  = play_btn  & ~play_q_reg;
    assign clear_press = clear_btn & ~clear_q_reg;

    // Outputs are registered alongside the state so they always describe the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            load_q_reg   <= 1'b0;
            play_q_reg   <= 1'b0;
            clear_q_reg  <= 1'b0;
            ld_note      <= 1'b0;
            ld_play      <= 1'b0;
            note_counter <= '0;
            clear        <= 1'b0;
            mute         <= 1'b1;
            busy         <= 1'b0;
        end else begin
            load_q_reg  <= load_btn;
            play_q_reg  <= play_btn;
            clear_q_reg <= clear_btn;
            ld_note     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (clear_press) begin
                        state_reg <= CLR;
                        timer_reg <= CLEAR_LOAD;
                        clear     <= 1'b1;
                        mute      <= 1'b1;
                        busy      <= 1'b1;
                    end else if (play_press) begin
                        state_reg    <= PLAY_NOTE;
                        timer_reg    <= NOTE_LOAD;
                        note_counter <= '0;
                        ld_play      <= 1'b1;
                        mute         <= 1'b0;
                        busy         <= 1'b1;
                    end else if (load_press) begin
                        state_reg <= REC;
                        ld_note   <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                REC: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
                PLAY_NOTE, PLAY_GAP: begin
                    if (clear_press) begin
                        state_reg <= CLR;
                        timer_reg <= CLEAR_LOAD;
                        ld_play   <= 1'b0;
                        clear     <= 1'b1;
                        mute      <= 1'b1;
                    end else if (play_press) begin
                        state_reg    <= IDLE;
                        ld_play      <= 1'b0;
                        note_counter <= '0;
                        mute         <= 1'b1;
                        busy         <= 1'b0;
                    end else if (timer_reg != '0) begin
                        timer_reg <= timer_reg - 24'd1;
                    end else if (state_reg == PLAY_NOTE && GAP_TICKS > 0) begin
                        state_reg <= PLAY_GAP;
                        timer_reg <= GAP_LOAD;
                        mute      <= 1'b1;
                    end else if (note_counter != LAST_SLOT) begin
                        state_reg    <= PLAY_NOTE;
                        timer_reg    <= NOTE_LOAD;
                        note_counter <= note_counter + 4'd1;
                        mute         <= 1'b0;
                    end else begin
`ifdef LOOP_PLAYBACK_EN
                        state_reg    <= PLAY_NOTE;
                        timer_reg    <= NOTE_LOAD;
                        note_counter <= '0;
                        mute         <= 1'b0;
`else
                        state_reg    <= IDLE;
                        ld_play      <= 1'b0;
                        note_counter <= '0;
                        mute         <= 1'b1;
                        busy         <= 1'b0;
`endif
                    end
                end
                CLR: begin
                    if (timer_reg == '0) begin
                        state_reg <= IDLE;
                        clear     <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg - 24'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ld_play   <= 1'b0;
                    clear     <= 1'b0;
                    mute      <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_seq_ctrl.sv
// Directed bench for note_seq_ctrl with short tempo parameters (4 note, 2 gap, 8 clear cycles).
`timescale 1ns/1ps
module tb_note_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_btn;
    logic       play_btn;
    logic       clear_btn;
    logic       ld_note;
    logic       ld_play;
    logic [3:0] note_counter;
    logic       clear;
    logic       mute;
    logic       busy;

    int checks = 0;
    int errors = 0;

    note_seq_ctrl #(
        .NOTE_COUNT(16),
        .NOTE_TICKS(4),
        .GAP_TICKS(2),
        .CLEAR_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .load_btn(load_btn),
        .play_btn(play_btn),
        .clear_btn(clear_btn),
        .ld_note(ld_note),
        .ld_play(ld_play),
        .note_counter(note_counter),
        .clear(clear),
        .mute(mute),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ld_note"}, 32'(ld_note), 32'd0);
        chk({tag, "_ld_play"}, 32'(ld_play), 32'd0);
        chk({tag, "_clear"}, 32'(clear), 32'd0);
        chk({tag, "_mute"}, 32'(mute), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_nc"}, 32'(note_counter), 32'd0);
    endtask

    initial begin
        int pulses;
        int first_at;
        int clr_cnt;
        int bad;

        // 1. reset
        reset = 1'b0; load_btn = 1'b0; play_btn = 1'b0; clear_btn = 1'b0;
        tick(); tick();
        chk_idle("reset");
        reset = 1'b1;
        tick();
        chk_idle("post_reset");
        $display("step reset done");

        // 2. held load button gives a single strobe
        load_btn = 1'b1;
        pulses = 0; first_at = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) chk("rec_busy", 32'(busy), 32'd1);
            if (ld_note) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
        end
        chk("load_pulses", 32'(pulses), 32'd1);
        chk("load_first", 32'(first_at), 32'd0);
        load_btn = 1'b0;
        tick();
        $display("step load: pulses=%0d first=%0d", pulses, first_at);

        // 3. full playback: 16 notes of 4 audible + 2 muted cycles
        play_btn = 1'b1;
        tick();
        play_btn = 1'b0;
        bad = 0;
        for (int c = 0; c < 96; c++) begin
            chk("play_nc", 32'(note_counter), 32'(c / 6));
            chk("play_mute", 32'(mute), 32'((c % 6) >= 4));
            chk("play_ld_play", 32'(ld_play), 32'd1);
            tick();
        end
`ifdef LOOP_PLAYBACK_EN
        chk("loop_nc", 32'(note_counter), 32'd0);
        chk("loop_ld_play", 32'(ld_play), 32'd1);
        chk("loop_mute", 32'(mute), 32'd0);
        play_btn = 1'b1;
        tick();
        play_btn = 1'b0;
        chk_idle("loop_stop");
`else
        chk_idle("play_end");
`endif
        $display("step playback done");

        // 4. stop at note 5
        play_btn = 1'b1;
        tick();
        play_btn = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        chk("stop_nc5", 32'(note_counter), 32'd5);
        chk("stop_mute5", 32'(mute), 32'd0);
        play_btn = 1'b1;
        tick();
        play_btn = 1'b0;
        chk_idle("stop");
        tick();
        $display("step stop at note 5 done");

        // 5. clear beats play; presses during the wipe are ignored
        clear_btn = 1'b1; play_btn = 1'b1;
        clr_cnt = 0; bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 0) begin
                chk("clr_first", 32'(clear), 32'd1);
                chk("clr_ld_play", 32'(ld_play), 32'd0);
                chk("clr_busy", 32'(busy), 32'd1);
                clear_btn = 1'b0; play_btn = 1'b0;
            end
            if (clear) clr_cnt++;
            if (ld_play || ld_note) bad++;
            if (i == 2) begin play_btn = 1'b1; load_btn = 1'b1; end
            if (i == 4) begin play_btn = 1'b0; load_btn = 1'b0; end
            if (i == 5) clear_btn = 1'b1;
            if (i == 6) clear_btn = 1'b0;
        end
        chk("clr_len", 32'(clr_cnt), 32'd8);
        chk("clr_ignored", 32'(bad), 32'd0);
        chk("clr_done_busy", 32'(busy), 32'd0);
        chk("clr_done_clear", 32'(clear), 32'd0);
        $display("step clear: cycles=%0d", clr_cnt);

        // 6. reset during a note
        play_btn = 1'b1;
        tick();
        play_btn = 1'b0;
        tick();
        chk("pre_rst_mute", 32'(mute), 32'd0);
        reset = 1'b0;
        tick();
        chk_idle("mid_reset");
        reset = 1'b1;
        tick();
        chk_idle("mid_reset_rel");
        $display("step mid-play reset done");

        // 7. play beats load; clear aborts playback
        play_btn = 1'b1; load_btn = 1'b1;
        tick();
        play_btn = 1'b0; load_btn = 1'b0;
        chk("prio_ld_note", 32'(ld_note), 32'd0);
        chk("prio_ld_play", 32'(ld_play), 32'd1);
        tick(); tick();
        clear_btn = 1'b1;
        tick();
        clear_btn = 1'b0;
        chk("abort_clear", 32'(clear), 32'd1);
        chk("abort_ld_play", 32'(ld_play), 32'd0);
        chk("abort_mute", 32'(mute), 32'd1);
        for (int i = 0; i < 8; i++) tick();
        chk("abort_done", 32'(busy), 32'd0);
        $display("step priority/abort done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
